uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer and round-robin two-port arbiter for the UART
// transmit shift datapath. Grants one byte per frame and walks the datapath
// through LOAD, START, DATA (8 bits) and STOP, one bit period per phase, while
// emitting the baud-rate enable tick.
// Optional feature: define UART_TX_PARITY_EN to add a PARITY phase between
// DATA and STOP, together with the par_bit / par_sel outputs.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req0_ack,
    output logic       req1_ack,
    output logic [7:0] tx_data,
    output logic       load,
    output logic       start,
    output logic       start_shift,
    output logic       baud_tick,
    output logic       busy,
    output logic       grant_id
`ifdef UART_TX_PARITY_EN
    ,
    output logic       par_bit,
    output logic       par_sel
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t           state, state_d;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic             last_grant;
    logic             grant;
    logic             winner;
    logic [7:0]       grant_data;
    logic             tick;

    assign baud_tick = tick;
    assign busy      = (state != IDLE);

    // Next-state logic: arbitration in IDLE, bit-period timing everywhere else.
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_cnt_d  = bit_cnt;
        grant      = 1'b0;
        winner     = last_grant;
        tick       = (state != IDLE) && (baud_cnt == CNT_MAX);

        if (state != IDLE) begin
            baud_cnt_d = tick ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                // req0 wins a tie only when req1 owned the previous frame.
                if (req0_valid && (!req1_valid || last_grant)) begin
                    grant  = 1'b1;
                    winner = 1'b0;
                end else if (req1_valid) begin
                    grant  = 1'b1;
                    winner = 1'b1;
                end
                if (grant) begin
                    state_d    = LOAD;
                    baud_cnt_d = '0;
                end
            end
            LOAD: begin
                if (tick) state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        grant_data = winner ? req1_data : req0_data;
    end

    // State, counters, grant capture and registered phase strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            tx_data     <= '0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            load        <= 1'b0;
            start       <= 1'b0;
            start_shift <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit     <= 1'b0;
            par_sel     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            baud_cnt    <= baud_cnt_d;
            bit_cnt     <= bit_cnt_d;
            req0_ack    <= grant && !winner;
            req1_ack    <= grant && winner;
            load        <= (state_d == LOAD);
            start       <= (state_d == START);
            start_shift <= (state_d == DATA);
`ifdef UART_TX_PARITY_EN
            par_sel     <= (state_d == PARITY);
`endif
            if (grant) begin
                tx_data    <= grant_data;
                grant_id   <= winner;
                last_grant <= winner;
`ifdef UART_TX_PARITY_EN
                par_bit    <= even_parity(grant_data);
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl with CLKS_PER_BIT=4.
// Expected grants are queued when a request is driven and checked at each ack;
// frame shape (strobe lengths, tick count, busy length) is checked per frame.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 12;
`else
    localparam int NBITS = 11;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ack, req1_ack;
    logic [7:0] tx_data;
    logic       load, start, start_shift, baud_tick, busy, grant_id;
`ifdef UART_TX_PARITY_EN
    logic       par_bit, par_sel;
`endif

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req0_ack   (req0_ack),
        .req1_ack   (req1_ack),
        .tx_data    (tx_data),
        .load       (load),
        .start      (start),
        .start_shift(start_shift),
        .baud_tick  (baud_tick),
        .busy       (busy),
        .grant_id   (grant_id)
`ifdef UART_TX_PARITY_EN
        ,
        .par_bit    (par_bit),
        .par_sel    (par_sel)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       gid;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int f_busy, f_tick, f_load, f_start, f_shift, f_ack0, f_ack1, f_excl;
`ifdef UART_TX_PARITY_EN
    int f_psel, f_psel_first;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic g);
        exp_t e;
        e.data = d;
        e.gid  = g;
        sb.push_back(e);
    endtask

    // Waits (bounded) for either ack; returns the number of cycles waited.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (req0_ack || req1_ack) break;
        end
    endtask

    // Compares the grant seen on the current ack cycle with the queued expectation.
    task automatic score_ack(input string tag);
        exp_t e;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, 32'(tx_data), 32'(e.data));
            check({tag, "_gid"}, 32'(grant_id), 32'(e.gid));
            check({tag, "_ackline"}, 32'({req1_ack, req0_ack}), e.gid ? 32'd2 : 32'd1);
        end
    endtask

    // Counts phase activity from the current negedge until busy drops (bounded).
    task automatic count_frame();
        f_busy = 0; f_tick = 0; f_load = 0; f_start = 0; f_shift = 0;
        f_ack0 = 0; f_ack1 = 0; f_excl = 0;
`ifdef UART_TX_PARITY_EN
        f_psel = 0; f_psel_first = -1;
`endif
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            f_busy++;
            f_tick  += baud_tick   ? 1 : 0;
            f_load  += load        ? 1 : 0;
            f_start += start       ? 1 : 0;
            f_shift += start_shift ? 1 : 0;
            f_ack0  += req0_ack    ? 1 : 0;
            f_ack1  += req1_ack    ? 1 : 0;
            if ((load && start) || (load && start_shift) || (start && start_shift)) f_excl++;
`ifdef UART_TX_PARITY_EN
            if (par_sel) begin
                if (f_psel_first < 0) f_psel_first = i;
                f_psel++;
            end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int cnt;

        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and quiet idle period.
        check("reset_outputs",
              32'({busy, load, start, start_shift, req0_ack, req1_ack, grant_id, baud_tick, tx_data}), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += (baud_tick || busy) ? 1 : 0;
        end
        check("idle_no_tick", cnt, 0);

        // Single request from req0, full frame shape.
        req0_valid = 1'b1; req0_data = 8'hA5; push_exp(8'hA5, 1'b0);
        wait_ack(cyc);
        check("ack_latency", cyc, 1);
        score_ack("single");
        req0_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
        check("par_bit_a5", 32'(par_bit), 0);
`endif
        count_frame();
        check("frame_busy", f_busy, FRAME);
        check("frame_ticks", f_tick, NBITS);
        check("frame_load", f_load, CPB);
        check("frame_start", f_start, CPB);
        check("frame_shift", f_shift, 8 * CPB);
        check("frame_ack_once", f_ack0 + f_ack1, 1);
        check("frame_excl", f_excl, 0);
`ifdef UART_TX_PARITY_EN
        check("frame_psel", f_psel, CPB);
        check("frame_psel_pos", f_psel_first, 10 * CPB);
`endif
        check("txdata_hold", 32'(tx_data), 32'hA5);

        // Both requesters continuously valid after reset: 0,1,0,1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b1);
        push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc);
            check("rr_gap", cyc, 1);
            score_ack("rr");
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            count_frame();
            check("rr_busy", f_busy, FRAME);
            check("rr_ack_once", f_ack0 + f_ack1, 1);
        end

        // req1 raised mid-frame is held off until IDLE.
        req0_valid = 1'b1; req0_data = 8'hA5; push_exp(8'hA5, 1'b0);
        wait_ack(cyc);
        score_ack("midA");
        req0_valid = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += req1_ack ? 1 : 0;
        end
        req1_valid = 1'b1; req1_data = 8'h22; push_exp(8'h22, 1'b1);
        count_frame();
        check("mid_rest_busy", f_busy, FRAME - 10);
        check("mid_no_ack1", cnt + f_ack1, 0);
        wait_ack(cyc);
        check("mid_ack_latency", cyc, 1);
        score_ack("midB");
        req1_valid = 1'b0;
        count_frame();
        check("mid_busy", f_busy, FRAME);

        // Reset during DATA at bit_cnt=3 aborts the frame.
        req0_valid = 1'b1; req0_data = 8'h3C; push_exp(8'h3C, 1'b0);
        wait_ack(cyc);
        score_ack("abort");
        req0_valid = 1'b0;
        repeat (22) @(negedge clk);
        check("abort_in_data", 32'(start_shift), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs",
              32'({busy, load, start, start_shift, req0_ack, req1_ack, grant_id, baud_tick, tx_data}), 0);
        req1_valid = 1'b1; req1_data = 8'h22; push_exp(8'h22, 1'b1);
        wait_ack(cyc);
        check("post_abort_latency", cyc, 1);
        score_ack("post_abort");
        req1_valid = 1'b0;
        count_frame();
        check("post_abort_busy", f_busy, FRAME);
        check("post_abort_ticks", f_tick, NBITS);
        check("post_abort_shift", f_shift, 8 * CPB);

`ifdef UART_TX_PARITY_EN
        // Odd-weight byte sets the parity bit.
        req0_valid = 1'b1; req0_data = 8'h07; push_exp(8'h07, 1'b0);
        wait_ack(cyc);
        score_ack("par07");
        check("par_bit_07", 32'(par_bit), 1);
        req0_valid = 1'b0;
        count_frame();
        check("par07_psel", f_psel, CPB);
        check("par07_psel_pos", f_psel_first, 10 * CPB);
        check("par07_busy", f_busy, FRAME);
`endif

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
